mic_delay_module: RTL and testbench
===================================

# mic_delay_module

Per-channel integer-sample delay bank for the 16-microphone beamformer. It sits between the CIC decimators and the summing stage. Each of 16 signed 19-bit PCM streams is delayed by a channel-specific number of samples derived from a 5-bit steering code, so that the downstream adder forms a steered beam. One new sample per channel is accepted on every clock edge; there is no separate sample strobe.

## Interface
- Parameters:
  - DATA_W, default 19: PCM sample width (two's complement).
  - DEPTH, default 32: history depth per channel in samples. Must be at least 30 and a power of two.
- Ports:
  - clk  input  1: single clock. Every register updates on its rising edge.
  - rst  input  1: reset, synchronous and active-high. Clears all history and output registers.
  - delay_select  input  5: steering code S, range 0..31, unsigned.
  - pcm_data_0 .. pcm_data_15  input  DATA_W each: channel k input sample. One new sample per clock.
  - delayed_pcm_data_0 .. delayed_pcm_data_15  output  DATA_W each: channel k delayed sample, registered.

## Operation
- Channel k delay in samples: D_k = (S * k) >> 4, truncating toward zero.
  - Channel 0 always has D = 0.
  - At S = 16, D_k = k.
  - Maximum delay is D_15 = 29, at S = 31.
- Each channel keeps a history of its last DEPTH input samples, implemented as a circular buffer with a shared write pointer.
- Every clock while rst = 0, for each channel k:
  - Write pcm_data_k into the history.
  - Load the output register with the input sample taken D_k clocks before the current edge.
  - When D_k = 0, this is the current input, taken directly rather than read from the buffer.
- Channels are fully independent. No arithmetic is performed on the data; samples pass through bit-exact.
- delay_select is sampled every clock and has no latch or handshake.
  - A change takes effect at the next edge; the output tap simply moves.
  - History is not cleared, so outputs may repeat or skip samples across the change.
- Before any history is written after reset, history reads return 0.

## Timing
- Reset (rst = 1 at an edge):
  - All delayed_pcm_data_k become 0.
  - All history entries read as 0.
  - The write pointer returns to 0.
  - Inputs presented during reset are discarded.
- rst asserted mid-stream behaves identically; operation restarts on the first edge with rst = 0.
- Latency for channel k:
  - A sample presented before edge n appears on delayed_pcm_data_k after edge n + D_k.
  - Total latency is 1 + D_k clocks, counted from input change to output change.
- After reset release, channel k outputs exactly D_k zeros (one per edge) before the first post-reset sample appears.
- Write-pointer wrap-around from DEPTH-1 to 0 must be seamless; no glitch or stale read at the wrap point.
- There are no combinational paths from any input to any output.

## Test plan
- Reset: drive all inputs to 0x7FFFF and hold rst = 1 for 3 clocks -> every output reads 0 after the first reset edge.
- Passthrough, S = 0: drive each channel k with 100*k + n on cycle n -> every output equals its input delayed by exactly 1 clock.
- Staircase, S = 16: drive every channel with ramp n = 1, 2, 3, ... after reset -> channel k shows k zeros, then 1, 2, 3, ...
- Maximum delay, S = 31: drive a single-cycle impulse 0x40000 on all channels -> channel 15 pulses 29 cycles after channel 0 and channel 1 pulses 1 cycle after channel 0. Every channel k pulses (31k >> 4) cycles after channel 0.
- Steering change and wrap: run 100 cycles with S = 16, then switch to S = 8 -> within 1 clock, channel 15 output equals its input from 8 cycles earlier, and no X or zero glitches occur across write-pointer wrap.
- Mid-stream reset: assert rst for 1 cycle during the ramp with S = 31 -> all outputs become 0, and channel 15 outputs 29 zeros after release before the ramp resumes.

Source files
------------

// File: rtl/mic_delay_module.sv
// mic_delay_module
// Integer-sample delay bank for a 16-microphone beamformer. Each channel keeps
// a circular history of its last DEPTH samples with a shared write pointer and
// outputs the sample taken D_k = (delay_select * k) >> 4 clocks earlier.
//
// Ports:
//   clk                    rising-edge clock, one new sample per channel per edge
//   rst                    synchronous active-high reset, clears history and outputs
//   delay_select[4:0]      steering code S, sampled every clock
//   pcm_data_0..15         channel input samples (DATA_W, two's complement)
//   delayed_pcm_data_0..15 registered delayed samples (DATA_W)
module mic_delay_module #(
  parameter int DATA_W = 19,
  parameter int DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        delay_select,
  input  logic [DATA_W-1:0] pcm_data_0,
  input  logic [DATA_W-1:0] pcm_data_1,
  input  logic [DATA_W-1:0] pcm_data_2,
  input  logic [DATA_W-1:0] pcm_data_3,
  input  logic [DATA_W-1:0] pcm_data_4,
  input  logic [DATA_W-1:0] pcm_data_5,
  input  logic [DATA_W-1:0] pcm_data_6,
  input  logic [DATA_W-1:0] pcm_data_7,
  input  logic [DATA_W-1:0] pcm_data_8,
  input  logic [DATA_W-1:0] pcm_data_9,
  input  logic [DATA_W-1:0] pcm_data_10,
  input  logic [DATA_W-1:0] pcm_data_11,
  input  logic [DATA_W-1:0] pcm_data_12,
  input  logic [DATA_W-1:0] pcm_data_13,
  input  logic [DATA_W-1:0] pcm_data_14,
  input  logic [DATA_W-1:0] pcm_data_15,
  output logic [DATA_W-1:0] delayed_pcm_data_0,
  output logic [DATA_W-1:0] delayed_pcm_data_1,
  output logic [DATA_W-1:0] delayed_pcm_data_2,
  output logic [DATA_W-1:0] delayed_pcm_data_3,
  output logic [DATA_W-1:0] delayed_pcm_data_4,
  output logic [DATA_W-1:0] delayed_pcm_data_5,
  output logic [DATA_W-1:0] delayed_pcm_data_6,
  output logic [DATA_W-1:0] delayed_pcm_data_7,
  output logic [DATA_W-1:0] delayed_pcm_data_8,
  output logic [DATA_W-1:0] delayed_pcm_data_9,
  output logic [DATA_W-1:0] delayed_pcm_data_10,
  output logic [DATA_W-1:0] delayed_pcm_data_11,
  output logic [DATA_W-1:0] delayed_pcm_data_12,
  output logic [DATA_W-1:0] delayed_pcm_data_13,
  output logic [DATA_W-1:0] delayed_pcm_data_14,
  output logic [DATA_W-1:0] delayed_pcm_data_15
);

  localparam int NCH = 16;
  localparam int AW  = $clog2(DEPTH);

  logic [DATA_W-1:0] w_in  [NCH];
  logic [DATA_W-1:0] w_out [NCH];
  logic [AW-1:0]     r_wr_ptr;

  assign w_in[0]  = pcm_data_0;
  assign w_in[1]  = pcm_data_1;
  assign w_in[2]  = pcm_data_2;
  assign w_in[3]  = pcm_data_3;
  assign w_in[4]  = pcm_data_4;
  assign w_in[5]  = pcm_data_5;
  assign w_in[6]  = pcm_data_6;
  assign w_in[7]  = pcm_data_7;
  assign w_in[8]  = pcm_data_8;
  assign w_in[9]  = pcm_data_9;
  assign w_in[10] = pcm_data_10;
  assign w_in[11] = pcm_data_11;
  assign w_in[12] = pcm_data_12;
  assign w_in[13] = pcm_data_13;
  assign w_in[14] = pcm_data_14;
  assign w_in[15] = pcm_data_15;

  assign delayed_pcm_data_0  = w_out[0];
  assign delayed_pcm_data_1  = w_out[1];
  assign delayed_pcm_data_2  = w_out[2];
  assign delayed_pcm_data_3  = w_out[3];
  assign delayed_pcm_data_4  = w_out[4];
  assign delayed_pcm_data_5  = w_out[5];
  assign delayed_pcm_data_6  = w_out[6];
  assign delayed_pcm_data_7  = w_out[7];
  assign delayed_pcm_data_8  = w_out[8];
  assign delayed_pcm_data_9  = w_out[9];
  assign delayed_pcm_data_10 = w_out[10];
  assign delayed_pcm_data_11 = w_out[11];
  assign delayed_pcm_data_12 = w_out[12];
  assign delayed_pcm_data_13 = w_out[13];
  assign delayed_pcm_data_14 = w_out[14];
  assign delayed_pcm_data_15 = w_out[15];

  // Shared write pointer; wraps naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) r_wr_ptr <= '0;
    else     r_wr_ptr <= r_wr_ptr + 1'b1;
  end

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DATA_W-1:0] r_hist [DEPTH];
    logic [DATA_W-1:0] r_out;
    logic [4:0]        w_dly;
    logic [AW-1:0]     w_rd_addr;

    // S*k fits in 9 bits (31*15 = 465); the shift keeps the integer part.
    assign w_dly     = 5'((9'(delay_select) * 9'(g)) >> 4);
    // The entry written D edges ago sits D slots behind the write pointer.
    assign w_rd_addr = r_wr_ptr - AW'(w_dly);

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) r_hist[i] <= '0;
        r_out <= '0;
      end else begin
        r_hist[r_wr_ptr] <= w_in[g];
        // Zero delay bypasses the buffer: the slot being written is not yet valid.
        if (w_dly == 5'd0) r_out <= w_in[g];
        else               r_out <= r_hist[w_rd_addr];
      end
    end

    assign w_out[g] = r_out;
  end

endmodule

// File: tb/tb_mic_delay_module.sv
module tb_mic_delay_module;

  localparam int W   = 19;
  localparam int NCH = 16;
  localparam int LOG = 1024;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [4:0]   dsel = '0;
  logic [W-1:0] pin  [NCH];
  logic [W-1:0] pout [NCH];

  int checks = 0;
  int errors = 0;

  // Bench model: inputs logged per post-reset edge index.
  logic [W-1:0] log_in [NCH][LOG];
  logic [4:0]   s_log  [LOG];
  int           n_post = 0;

  // Hand-derived (31*k)>>4 table for the maximum steering code.
  int tbl31 [NCH] = '{0,1,3,5,7,9,11,13,15,17,19,21,23,25,27,29};

  always #5 clk = ~clk;

  mic_delay_module #(.DATA_W(W), .DEPTH(32)) dut (
    .clk(clk), .rst(rst), .delay_select(dsel),
    .pcm_data_0(pin[0]),   .pcm_data_1(pin[1]),   .pcm_data_2(pin[2]),   .pcm_data_3(pin[3]),
    .pcm_data_4(pin[4]),   .pcm_data_5(pin[5]),   .pcm_data_6(pin[6]),   .pcm_data_7(pin[7]),
    .pcm_data_8(pin[8]),   .pcm_data_9(pin[9]),   .pcm_data_10(pin[10]), .pcm_data_11(pin[11]),
    .pcm_data_12(pin[12]), .pcm_data_13(pin[13]), .pcm_data_14(pin[14]), .pcm_data_15(pin[15]),
    .delayed_pcm_data_0(pout[0]),   .delayed_pcm_data_1(pout[1]),
    .delayed_pcm_data_2(pout[2]),   .delayed_pcm_data_3(pout[3]),
    .delayed_pcm_data_4(pout[4]),   .delayed_pcm_data_5(pout[5]),
    .delayed_pcm_data_6(pout[6]),   .delayed_pcm_data_7(pout[7]),
    .delayed_pcm_data_8(pout[8]),   .delayed_pcm_data_9(pout[9]),
    .delayed_pcm_data_10(pout[10]), .delayed_pcm_data_11(pout[11]),
    .delayed_pcm_data_12(pout[12]), .delayed_pcm_data_13(pout[13]),
    .delayed_pcm_data_14(pout[14]), .delayed_pcm_data_15(pout[15])
  );

  // Advance one edge with the currently driven inputs; outputs are stable #1 later.
  task automatic tick();
    if (!rst) begin
      for (int k = 0; k < NCH; k++) log_in[k][n_post] = pin[k];
      s_log[n_post] = dsel;
    end
    @(posedge clk);
    #1;
    if (rst) n_post = 0;
    else     n_post++;
  endtask

  // Expected output of channel k after the most recent edge.
  function automatic logic [W-1:0] model_out(input int k);
    int m, d, idx;
    m   = n_post - 1;
    d   = (int'(s_log[m]) * k) >> 4;
    idx = m - d;
    return (idx >= 0) ? log_in[k][idx] : '0;
  endfunction

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    for (int c = 0; c < cycles; c++) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    for (int k = 0; k < NCH; k++) pin[k] = 19'h7FFFF;
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      for (int k = 0; k < NCH; k++) begin
        checks++;
        if (pout[k] !== '0) begin
          errors++;
          $display("FAIL reset ch%0d cyc%0d: got %h expected 0", k, c, pout[k]);
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_passthrough();
    logic [W-1:0] e;
    do_reset(1);
    dsel = 5'd0;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NCH; k++) pin[k] = W'(100 * k + n);
      tick();
      for (int k = 0; k < NCH; k++) begin
        e = W'(100 * k + n);
        checks++;
        if (pout[k] !== e) begin
          errors++;
          $display("FAIL passthrough ch%0d n%0d: got %0d expected %0d", k, n, pout[k], e);
        end
      end
    end
  endtask

  task automatic test_staircase();
    logic [W-1:0] e;
    do_reset(1);
    dsel = 5'd16;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NCH; k++) pin[k] = W'(n + 1);
      tick();
      for (int k = 0; k < NCH; k++) begin
        e = (n >= k) ? W'(n - k + 1) : '0;
        checks++;
        if (pout[k] !== e) begin
          errors++;
          $display("FAIL staircase ch%0d n%0d: got %0d expected %0d", k, n, pout[k], e);
        end
      end
    end
  endtask

  task automatic test_max_delay();
    logic [W-1:0] e;
    int first_hit [NCH];
    do_reset(1);
    dsel = 5'd31;
    for (int k = 0; k < NCH; k++) first_hit[k] = -1;
    for (int n = 0; n < 36; n++) begin
      for (int k = 0; k < NCH; k++) pin[k] = (n == 0) ? 19'h40000 : '0;
      tick();
      for (int k = 0; k < NCH; k++) begin
        e = (n == tbl31[k]) ? 19'h40000 : '0;
        if (pout[k] === 19'h40000 && first_hit[k] < 0) first_hit[k] = n;
        checks++;
        if (pout[k] !== e) begin
          errors++;
          $display("FAIL max_delay ch%0d n%0d: got %h expected %h", k, n, pout[k], e);
        end
      end
    end
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (first_hit[k] - first_hit[0] != tbl31[k] || first_hit[0] != 0) begin
        errors++;
        $display("FAIL max_delay_offset ch%0d: got %0d cycles after ch0 expected %0d",
                 k, first_hit[k] - first_hit[0], tbl31[k]);
      end
    end
  endtask

  task automatic test_steer_wrap();
    logic [W-1:0] e;
    do_reset(1);
    dsel = 5'd16;
    for (int n = 0; n < 130; n++) begin
      if (n == 100) dsel = 5'd8;
      for (int k = 0; k < NCH; k++) pin[k] = W'($urandom_range(1, 19'h7FFFF));
      tick();
      for (int k = 0; k < NCH; k++) begin
        e = model_out(k);
        checks++;
        if (pout[k] !== e) begin
          errors++;
          $display("FAIL steer_wrap ch%0d n%0d S%0d: got %h expected %h", k, n, dsel, pout[k], e);
        end
        // Past the fill-up period, random inputs are never zero.
        if (n >= 29) begin
          checks++;
          if (pout[k] === '0 || $isunknown(pout[k])) begin
            errors++;
            $display("FAIL steer_glitch ch%0d n%0d: got %h expected nonzero", k, n, pout[k]);
          end
        end
      end
      if (n == 100) begin
        // First edge at S=8: channel 15 delay is 7, its sample from edge 93.
        checks++;
        if (pout[15] !== log_in[15][93]) begin
          errors++;
          $display("FAIL steer_switch ch15: got %h expected %h", pout[15], log_in[15][93]);
        end
      end
    end
  endtask

  task automatic test_midreset();
    logic [W-1:0] e;
    int val = 1;
    do_reset(1);
    dsel = 5'd31;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NCH; k++) pin[k] = W'(val);
      val++;
      tick();
      for (int k = 0; k < NCH; k++) begin
        e = model_out(k);
        checks++;
        if (pout[k] !== e) begin
          errors++;
          $display("FAIL midreset_pre ch%0d n%0d: got %h expected %h", k, n, pout[k], e);
        end
      end
    end
    rst = 1'b1;
    for (int k = 0; k < NCH; k++) pin[k] = W'(val);
    val++;
    tick();
    rst = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (pout[k] !== '0) begin
        errors++;
        $display("FAIL midreset_clear ch%0d: got %h expected 0", k, pout[k]);
      end
    end
    // Ramp resumes at value 42; channel 15 shows 29 zeros, then 42, 43, ...
    for (int n = 0; n < 35; n++) begin
      for (int k = 0; k < NCH; k++) pin[k] = W'(val);
      val++;
      tick();
      e = (n >= 29) ? W'(42 + n - 29) : '0;
      checks++;
      if (pout[15] !== e) begin
        errors++;
        $display("FAIL midreset_ch15 n%0d: got %0d expected %0d", n, pout[15], e);
      end
      for (int k = 0; k < NCH; k++) begin
        e = model_out(k);
        checks++;
        if (pout[k] !== e) begin
          errors++;
          $display("FAIL midreset_post ch%0d n%0d: got %h expected %h", k, n, pout[k], e);
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NCH; k++) pin[k] = '0;
    #1;
    test_reset();
    test_passthrough();
    test_staircase();
    test_max_delay();
    test_steer_wrap();
    test_midreset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
